// File: rtl/swap_pair_monitor.sv
// ---------------------------------------------------------------------------
// swap_pair_monitor
//
// Downstream checker for the two-flop swap stage (flop1/flop2 pair). It
// samples the pair every clock and checks two rules: the two bits must be
// complementary, and they must swap places every cycle. It tracks lock
// status, counts good and bad samples, and reports a sticky error. Its
// outputs feed the status/debug register block.
//
// Parameters
//   LOCK_CYCLES  consecutive good samples needed to reach LOCKED (>=1)
//   UNLOCK_ERRS  consecutive bad samples in LOCKED that drop to LOST (>=1)
//   CNT_W        width of good_count / err_count (saturating)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   pair_a      flop1 output of the swap stage
//   pair_b      flop2 output of the swap stage
//   clear       synchronous clear of counters, err_flag, err_code and FSM
//   locked      1 while the FSM is in LOCKED
//   err_flag    sticky, set on any bad sample
//   err_code    cause of the last bad sample: 01 not complementary,
//               10 no swap, 11 both
//   good_count  good samples since clear/reset (saturating)
//   err_count   bad samples since clear/reset (saturating)
//
// Optional feature, macro SWAP_MON_SNAPSHOT_EN:
//   snap_good   good_count captured on every LOCKED -> LOST transition
//   snap_vld    one-cycle pulse whenever snap_good updates
// Without the macro these ports and their logic do not exist.
//
// Timing: a pair driven onto the inputs after edge k is captured into s_*
// at edge k+1 and judged into the registered outputs at edge k+2.
// ---------------------------------------------------------------------------
module swap_pair_monitor #(
  parameter int LOCK_CYCLES = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pair_a,
  input  logic             pair_b,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count
`ifdef SWAP_MON_SNAPSHOT_EN
  ,
  output logic [CNT_W-1:0] snap_good,
  output logic             snap_vld
`endif
);

  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam int BAD_W = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t           state;
  logic             s_a, s_b, s_vld;
  logic             p_a, p_b, p_vld;
  logic [RUN_W-1:0] run_cnt;
  logic [BAD_W-1:0] bad_run;

  logic             nc, ns, bad;
  logic [RUN_W-1:0] run_inc;
  logic [BAD_W-1:0] bad_inc;

  // Judgement of the current sample against the previous one. Without a
  // valid history only the complementary rule can be applied.
  always_comb begin
    nc      = (s_a == s_b);
    ns      = p_vld && ((s_a != p_b) || (s_b != p_a));
    bad     = nc | ns;
    run_inc = run_cnt + 1'b1;
    bad_inc = bad_run + 1'b1;
  end

  // Sample stage, history, counters, error reporting and lock FSM.
  // s_vld marks that s_* holds a real sample; the reset value of s_* is
  // never judged. IDLE and LOST share the acquisition path with ACQUIRE,
  // starting from a run of zero, so the first good sample gives run 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_a        <= 1'b0;
      s_b        <= 1'b0;
      s_vld      <= 1'b0;
      p_a        <= 1'b0;
      p_b        <= 1'b0;
      p_vld      <= 1'b0;
      state      <= IDLE;
      locked     <= 1'b0;
      run_cnt    <= '0;
      bad_run    <= '0;
      good_count <= '0;
      err_count  <= '0;
      err_flag   <= 1'b0;
      err_code   <= 2'b00;
`ifdef SWAP_MON_SNAPSHOT_EN
      snap_good  <= '0;
      snap_vld   <= 1'b0;
`endif
    end else begin
      s_a   <= pair_a;
      s_b   <= pair_b;
      s_vld <= 1'b1;
`ifdef SWAP_MON_SNAPSHOT_EN
      snap_vld <= 1'b0;
`endif
      if (clear) begin
        // The sample judged in this cycle is dropped and history restarts.
        p_vld      <= 1'b0;
        state      <= IDLE;
        locked     <= 1'b0;
        run_cnt    <= '0;
        bad_run    <= '0;
        good_count <= '0;
        err_count  <= '0;
        err_flag   <= 1'b0;
        err_code   <= 2'b00;
`ifdef SWAP_MON_SNAPSHOT_EN
        snap_good  <= '0;
`endif
      end else if (s_vld) begin
        p_a   <= s_a;
        p_b   <= s_b;
        p_vld <= 1'b1;

        if (bad) begin
          err_flag <= 1'b1;
          err_code <= {ns, nc};
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
        end else if (good_count != '1) begin
          good_count <= good_count + 1'b1;
        end

        case (state)
          IDLE, ACQUIRE, LOST: begin
            if (bad) begin
              run_cnt <= '0;
              if (state == IDLE) begin
                state <= ACQUIRE;
              end
            end else if (run_inc == RUN_W'(LOCK_CYCLES)) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              run_cnt <= '0;
              bad_run <= '0;
            end else begin
              state   <= ACQUIRE;
              run_cnt <= run_inc;
            end
          end
          LOCKED: begin
            if (!bad) begin
              bad_run <= '0;
            end else if (bad_inc == BAD_W'(UNLOCK_ERRS)) begin
              state   <= LOST;
              locked  <= 1'b0;
              bad_run <= '0;
              run_cnt <= '0;
`ifdef SWAP_MON_SNAPSHOT_EN
              snap_good <= good_count;
              snap_vld  <= 1'b1;
`endif
            end else begin
              bad_run <= bad_inc;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swap_pair_monitor.sv
// ---------------------------------------------------------------------------
// tb_swap_pair_monitor
//
// Self-checking bench for swap_pair_monitor. Two instances share the same
// stimulus: one with the default 16-bit counters and one with 4-bit counters
// so saturation is reachable. A hand-derived vector table covers lock,
// error codes, loss/relock and clear; a randomized phase is checked against
// a behavioural model; directed sequences cover saturation and a reset
// asserted between clock edges.
// ---------------------------------------------------------------------------
module tb_swap_pair_monitor;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 2;
  localparam int W      = 16;
  localparam int W4     = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pair_a = 1'b0;
  logic          pair_b = 1'b0;
  logic          clear = 1'b0;

  logic          locked, err_flag;
  logic [1:0]    err_code;
  logic [W-1:0]  good_count, err_count;
  logic          locked4, err_flag4;
  logic [1:0]    err_code4;
  logic [W4-1:0] good_count4, err_count4;
`ifdef SWAP_MON_SNAPSHOT_EN
  logic [W-1:0]  snap_good;
  logic          snap_vld;
  logic [W4-1:0] snap_good4;
  logic          snap_vld4;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: plain counts and streak lengths.
  bit  mPendV, mPendA, mPendB;
  bit  mHistV, mHistA, mHistB;
  bit  mLocked, mFlag, mSnapV;
  bit  [1:0] mCode;
  int  mGood, mErr, mStreakG, mStreakB, mSnap;

  typedef struct {
    bit       a;
    bit       b;
    bit       clr;
    bit       lk;
    bit       fl;
    bit [1:0] code;
    int       good;
    int       err;
  } vec_t;

  vec_t tbl[19];

  swap_pair_monitor #(.LOCK_CYCLES(LOCK), .UNLOCK_ERRS(UNLOCK), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .pair_a(pair_a), .pair_b(pair_b), .clear(clear),
    .locked(locked), .err_flag(err_flag), .err_code(err_code),
    .good_count(good_count), .err_count(err_count)
`ifdef SWAP_MON_SNAPSHOT_EN
    , .snap_good(snap_good), .snap_vld(snap_vld)
`endif
  );

  swap_pair_monitor #(.LOCK_CYCLES(LOCK), .UNLOCK_ERRS(UNLOCK), .CNT_W(W4)) dut4 (
    .clock(clock), .reset(reset), .pair_a(pair_a), .pair_b(pair_b), .clear(clear),
    .locked(locked4), .err_flag(err_flag4), .err_code(err_code4),
    .good_count(good_count4), .err_count(err_count4)
`ifdef SWAP_MON_SNAPSHOT_EN
    , .snap_good(snap_good4), .snap_vld(snap_vld4)
`endif
  );

  always #5 clock = ~clock;

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void modelReset();
    mPendV = 0; mPendA = 0; mPendB = 0;
    mHistV = 0; mHistA = 0; mHistB = 0;
    mLocked = 0; mFlag = 0; mSnapV = 0; mCode = 2'b00;
    mGood = 0; mErr = 0; mStreakG = 0; mStreakB = 0; mSnap = 0;
  endfunction

  // One clock edge: judge the held sample (or clear), then take the new pair.
  function automatic void modelStep(bit a, bit b, bit clr);
    bit nc, ns;
    mSnapV = 0;
    if (clr) begin
      mGood = 0; mErr = 0; mFlag = 0; mCode = 2'b00;
      mLocked = 0; mStreakG = 0; mStreakB = 0; mHistV = 0; mSnap = 0;
    end else if (mPendV) begin
      nc = (mPendA == mPendB);
      ns = mHistV && ((mPendA != mHistB) || (mPendB != mHistA));
      if (nc || ns) begin
        mErr++;
        mFlag = 1;
        mCode = {ns, nc};
        if (mLocked) begin
          mStreakB++;
          if (mStreakB == UNLOCK) begin
            mLocked = 0; mStreakB = 0; mStreakG = 0;
            mSnap = mGood; mSnapV = 1;
          end
        end else begin
          mStreakG = 0;
        end
      end else begin
        mGood++;
        if (mLocked) begin
          mStreakB = 0;
        end else begin
          mStreakG++;
          if (mStreakG == LOCK) begin
            mLocked = 1; mStreakG = 0; mStreakB = 0;
          end
        end
      end
      mHistA = mPendA; mHistB = mPendB; mHistV = 1;
    end
    mPendA = a; mPendB = b; mPendV = 1;
  endfunction

  task automatic checkVal(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit clr);
    pair_a = a;
    pair_b = b;
    clear  = clr;
    @(posedge clock);
    modelStep(a, b, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".locked"}, locked, mLocked);
    checkVal({tag, ".err_flag"}, err_flag, mFlag);
    checkVal({tag, ".err_code"}, err_code, mCode);
    checkVal({tag, ".good_count"}, good_count, sat(mGood, W));
    checkVal({tag, ".err_count"}, err_count, sat(mErr, W));
    checkVal({tag, ".locked4"}, locked4, mLocked);
    checkVal({tag, ".good_count4"}, good_count4, sat(mGood, W4));
    checkVal({tag, ".err_count4"}, err_count4, sat(mErr, W4));
`ifdef SWAP_MON_SNAPSHOT_EN
    checkVal({tag, ".snap_vld"}, snap_vld, mSnapV);
    checkVal({tag, ".snap_good"}, snap_good, sat(mSnap, W));
`endif
  endtask

  task automatic doReset();
    reset  = 1'b0;
    clear  = 1'b0;
    pair_a = 1'b0;
    pair_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    modelReset();
    checkOutput("reset");
    reset = 1'b1;
  endtask

  task automatic setVec(input int i, input bit a, input bit b, input bit clr,
                        input bit lk, input bit fl, input bit [1:0] code,
                        input int good, input int err);
    tbl[i].a = a; tbl[i].b = b; tbl[i].clr = clr;
    tbl[i].lk = lk; tbl[i].fl = fl; tbl[i].code = code;
    tbl[i].good = good; tbl[i].err = err;
  endtask

  initial begin
    bit la, lb, na, nb, nclr;
    int r;

    // Each row: pair/clear driven this step, then the outputs expected after
    // the next edge, which judge the previous row's pair under this clear.
    setVec( 0, 0, 1, 0, 0, 0, 2'b00,  0, 0);
    setVec( 1, 1, 0, 0, 0, 0, 2'b00,  1, 0);
    setVec( 2, 0, 1, 0, 0, 0, 2'b00,  2, 0);
    setVec( 3, 1, 0, 0, 0, 0, 2'b00,  3, 0);
    setVec( 4, 0, 1, 0, 1, 0, 2'b00,  4, 0);
    setVec( 5, 1, 0, 0, 1, 0, 2'b00,  5, 0);
    setVec( 6, 1, 0, 0, 1, 0, 2'b00,  6, 0);
    setVec( 7, 1, 0, 0, 1, 1, 2'b10,  6, 1);
    setVec( 8, 0, 1, 0, 0, 1, 2'b10,  6, 2);
    setVec( 9, 1, 0, 0, 0, 1, 2'b10,  7, 2);
    setVec(10, 0, 1, 0, 0, 1, 2'b10,  8, 2);
    setVec(11, 1, 0, 0, 0, 1, 2'b10,  9, 2);
    setVec(12, 0, 1, 0, 1, 1, 2'b10, 10, 2);
    setVec(13, 1, 1, 0, 1, 1, 2'b10, 11, 2);
    setVec(14, 0, 1, 0, 1, 1, 2'b11, 11, 3);
    setVec(15, 1, 0, 0, 0, 1, 2'b10, 11, 4);
    setVec(16, 1, 1, 0, 0, 1, 2'b10, 12, 4);
    setVec(17, 0, 1, 1, 0, 0, 2'b00,  0, 0);
    setVec(18, 1, 0, 0, 0, 0, 2'b00,  1, 0);

    $display("[TB] start");
    doReset();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].clr);
      checkVal($sformatf("tbl%0d.locked", i), locked, tbl[i].lk);
      checkVal($sformatf("tbl%0d.err_flag", i), err_flag, tbl[i].fl);
      checkVal($sformatf("tbl%0d.err_code", i), err_code, tbl[i].code);
      checkVal($sformatf("tbl%0d.good_count", i), good_count, tbl[i].good);
      checkVal($sformatf("tbl%0d.err_count", i), err_count, tbl[i].err);
    end

    // Saturation: 21 alternating pairs give 20 judged good samples.
    doReset();
    for (int i = 0; i < 21; i++) begin
      applyStimulus(i[0], !i[0], 1'b0);
    end
    checkOutput("sat");
    checkVal("sat.good_count4_const", good_count4, 15);
    checkVal("sat.good_count_const", good_count, 20);
    checkVal("sat.locked_const", locked, 1);

    // Randomized run against the model: mostly correct swaps, some faults.
    doReset();
    la = 1'b1;
    lb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80) begin
        if (la != lb) begin
          na = lb; nb = la;
        end else begin
          na = 1'b0; nb = 1'b1;
        end
      end else begin
        na = 1'($urandom_range(0, 1));
        nb = 1'($urandom_range(0, 1));
      end
      nclr = ($urandom_range(0, 99) < 2);
      applyStimulus(na, nb, nclr);
      checkOutput($sformatf("rnd%0d", i));
      la = na;
      lb = nb;
    end

    // Reset asserted between edges while LOCKED clears outputs at once.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[0], !i[0], 1'b0);
    end
    checkVal("midreset.locked_before", locked, 1);
    #3;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset");
    checkVal("midreset.locked_const", locked, 0);
    #2;
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
